cordic_post: RTL and testbench
==============================

CORDIC_POST -- requirements
Module: cordic_post

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- VALUE_WIDTH, 8: x/y magnitude width; x/y ports are VALUE_WIDTH+1 bits signed.
- ADDRESS_WIDTH, 8: angle width; z ports are ADDRESS_WIDTH+1 bits signed.
- STAGES, 8: pipeline depth, in cycles, of the element chain that feeds this block.
- MODE, 1: 1 = rotation, 0 = vectoring; must match the chain.
- QUARTER_TURN, 2**(ADDRESS_WIDTH-1): code for +90 degrees in z units.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- CLK  in  1  single system clock; all flops on the rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample enters the chain this cycle.
- quad_in  in  2  pre-rotation tag for that sample: 0 none, 1 pre-rotated -90, 2 pre-rotated +90, 3 illegal.
- x_n, y_n  in  VALUE_WIDTH+1 signed  last chain element outputs.
- z_n  in  ADDRESS_WIDTH+1 signed  last chain element output.
- x_out, y_out  out  VALUE_WIDTH+1 signed  compensated, restored result.
- z_out  out  ADDRESS_WIDTH+1 signed  restored angle.
- out_valid  out  1  result valid, one-cycle pulse per sample.
- err_quad  out  1  sticky flag: an illegal tag reached output.
- sample_cnt  out  16  count of out_valid pulses.

Function
REQ-003 The block SHALL delay in_valid and quad_in by STAGES cycles through a shift register, so that they align with x_n/y_n/z_n.
REQ-004 Stage A SHALL register the gain-compensated values gx = (v>>>1)+(v>>>3)-(v>>>6)-(v>>>9) for v = x_n and for v = y_n.
- Each term is an individually floored arithmetic shift.
- The sum is formed at VALUE_WIDTH+3 bits and then truncated.
REQ-005 Stage A SHALL register z_n unchanged, together with the aligned valid and tag.
REQ-006 Stage B SHALL restore the quadrant from the tag:
- tag 0 or 3: x_out = gx, y_out = gy.
- tag 1: x_out = -gy, y_out = gx.
- tag 2: x_out = gy, y_out = -gx.
REQ-007 For z_out, MODE=1 SHALL pass z unchanged for every tag.
REQ-008 For z_out, MODE=0 SHALL apply:
- tag 1: z + QUARTER_TURN.
- tag 2: z - QUARTER_TURN.
- tag 0 or 3: z unchanged.
- Results wrap modulo 2^(ADDRESS_WIDTH+1) with no saturation.
REQ-009 out_valid SHALL assert exactly STAGES+2 cycles after the cycle in which in_valid was sampled high.
REQ-010 Back-to-back in_valid SHALL yield back-to-back out_valid with no bubbles; throughput is one sample per cycle.
REQ-011 x_out/y_out/z_out SHALL hold their last value while out_valid is low.
REQ-012 The data path SHALL register every cycle; only out_valid qualifies data.
REQ-013 err_quad SHALL set in the cycle out_valid asserts for a tag-3 sample, and SHALL remain set until reset.
REQ-014 sample_cnt SHALL increment by 1 on each out_valid and wrap from 16'hFFFF to 0.
REQ-015 Tag and valid SHALL travel together; a tag is never applied to a different sample's data.

Reset
REQ-016 While RESET_n is low, the following SHALL all be 0, asynchronously:
- every output;
- the valid/tag delay line;
- the stage A and stage B registers.
REQ-017 Assertion of RESET_n mid-stream SHALL discard every sample in flight; no out_valid SHALL appear for samples entered before or during reset.
REQ-018 After RESET_n deasserts, the first out_valid SHALL occur only for an in_valid sampled after deassertion.

Verification
REQ-019 The bench SHALL cover these directed scenarios (VALUE_WIDTH=8, STAGES=8 unless noted):
- Scenario 1: in_valid pulse with quad_in=0, then x_n=200, y_n=-200 aligned 8 cycles later -> at cycle 10: out_valid=1, x_out=122, y_out=-120, sample_cnt=1.
- Scenario 2: same data with quad_in=1 -> x_out=120, y_out=122. With quad_in=2 -> x_out=-120, y_out=-122.
- Scenario 3: MODE=0, ADDRESS_WIDTH=8, QUARTER_TURN=128, z_n=200, quad_in=1 -> z_out=-184 (wrap). With quad_in=2 and z_n=-200 -> z_out=184.
- Scenario 4: 20 consecutive in_valid cycles with cycling tags -> 20 consecutive out_valid, each with the correct tag applied, and sample_cnt=20.
- Scenario 5: quad_in=3 sample -> data passes as tag 0, err_quad rises with out_valid and stays high.
- Scenario 6: RESET_n pulsed low 4 cycles after 3 samples enter -> all outputs 0 and no out_valid afterwards until a new sample, which then appears STAGES+2 cycles later.

Source files
------------

// File: rtl/cordic_post_if.sv
// Bus between a CORDIC element chain and its post-processing block:
// chain-side outputs plus the aligned, compensated and restored results.
interface cordic_post_if #(
  parameter int VALUE_WIDTH   = 8,
  parameter int ADDRESS_WIDTH = 8
);
  logic                       in_valid;
  logic [1:0]                 quad_in;
  logic signed [VALUE_WIDTH:0]   x_n;
  logic signed [VALUE_WIDTH:0]   y_n;
  logic signed [ADDRESS_WIDTH:0] z_n;

  logic signed [VALUE_WIDTH:0]   x_out;
  logic signed [VALUE_WIDTH:0]   y_out;
  logic signed [ADDRESS_WIDTH:0] z_out;
  logic                       out_valid;
  logic                       err_quad;
  logic [15:0]                sample_cnt;

  modport master (
    output in_valid, quad_in, x_n, y_n, z_n,
    input  x_out, y_out, z_out, out_valid, err_quad, sample_cnt
  );

  modport slave (
    input  in_valid, quad_in, x_n, y_n, z_n,
    output x_out, y_out, z_out, out_valid, err_quad, sample_cnt
  );
endinterface

// File: rtl/cordic_post.sv
// CORDIC post-processing: aligns valid/tag with the chain output, applies
// gain compensation, then undoes the quadrant pre-rotation.
module cordic_post #(
  parameter int VALUE_WIDTH   = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int STAGES        = 8,
  parameter bit MODE          = 1'b1,
  parameter int QUARTER_TURN  = 2 ** (ADDRESS_WIDTH - 1)
) (
  input logic          CLK,
  input logic          RESET_n,
  cordic_post_if.slave bus
);
  localparam int VW = VALUE_WIDTH + 1;
  localparam int AW = ADDRESS_WIDTH + 1;
  localparam int SW = VALUE_WIDTH + 3;
  localparam logic signed [AW-1:0] QT = AW'(QUARTER_TURN);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_NEG90 = 2'd1,
    TAG_POS90 = 2'd2,
    TAG_BAD   = 2'd3
  } tag_t;

  logic [STAGES-1:0] vld_sr;
  tag_t              tag_sr [STAGES];

  logic                 a_valid;
  tag_t                 a_tag;
  logic signed [VW-1:0] a_gx, a_gy;
  logic signed [AW-1:0] a_z;

  logic signed [VW-1:0] b_x, b_y;
  logic signed [AW-1:0] b_z;
  logic                 b_valid;
  logic                 b_err;
  logic [15:0]          b_cnt;

  logic signed [VW-1:0] nx, ny;
  logic signed [AW-1:0] nz;

  // 1/K ~= 0.607 via four floored shifts, summed with two guard bits
  function automatic logic signed [VW-1:0] gain(input logic signed [VW-1:0] v);
    logic signed [SW-1:0] ve;
    logic signed [SW-1:0] s;
    ve = {{(SW-VW){v[VW-1]}}, v};
    s  = (ve >>> 1) + (ve >>> 3) - (ve >>> 6) - (ve >>> 9);
    return s[VW-1:0];
  endfunction

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      vld_sr <= '0;
      for (int unsigned i = 0; i < STAGES; i++) tag_sr[i] <= TAG_NONE;
    end else begin
      vld_sr[0] <= bus.in_valid;
      tag_sr[0] <= tag_t'(bus.quad_in);
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      a_valid <= 1'b0;
      a_tag   <= TAG_NONE;
      a_gx    <= '0;
      a_gy    <= '0;
      a_z     <= '0;
    end else begin
      a_valid <= vld_sr[STAGES-1];
      a_tag   <= tag_sr[STAGES-1];
      a_gx    <= gain(bus.x_n);
      a_gy    <= gain(bus.y_n);
      a_z     <= bus.z_n;
    end
  end

  always_comb begin
    nx = a_gx;
    ny = a_gy;
    nz = a_z;
    case (a_tag)
      TAG_NEG90: begin
        nx = -a_gy;
        ny = a_gx;
        if (MODE == 1'b0) nz = a_z + QT;
      end
      TAG_POS90: begin
        nx = a_gy;
        ny = -a_gx;
        if (MODE == 1'b0) nz = a_z - QT;
      end
      default: ;
    endcase
  end

  // Stage A runs every cycle; the output stage loads only for a valid sample
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      b_x     <= '0;
      b_y     <= '0;
      b_z     <= '0;
      b_valid <= 1'b0;
      b_err   <= 1'b0;
      b_cnt   <= '0;
    end else begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_x   <= nx;
        b_y   <= ny;
        b_z   <= nz;
        b_cnt <= b_cnt + 16'd1;
        if (a_tag == TAG_BAD) b_err <= 1'b1;
      end
    end
  end

  assign bus.x_out      = b_x;
  assign bus.y_out      = b_y;
  assign bus.z_out      = b_z;
  assign bus.out_valid  = b_valid;
  assign bus.err_quad   = b_err;
  assign bus.sample_cnt = b_cnt;
endmodule

// File: tb/tb_cordic_post.sv
// Directed bench for cordic_post: rotation-mode and vectoring-mode instances
// share one stimulus stream; outputs are checked every cycle against expectations.
module tb_cordic_post;
  logic              CLK = 1'b0;
  logic              RESET_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [1:0]        quad = 2'd0;
  logic signed [8:0] x_n = '0;
  logic signed [8:0] y_n = '0;
  logic signed [8:0] z_n = '0;

  int errors = 0;
  int checks = 0;
  string scn = "init";

  int sq [32];
  int sx [32];
  int sy [32];
  int sz [32];
  int ex [32];
  int ey [32];
  int ez [32];
  int ez0 [32];

  int exp_cnt = 0;
  int exp_err = 0;
  int last_x = 0, last_y = 0, last_z = 0, last_z0 = 0;

  cordic_post_if #(.VALUE_WIDTH(8), .ADDRESS_WIDTH(8)) bus1 ();
  cordic_post_if #(.VALUE_WIDTH(8), .ADDRESS_WIDTH(8)) bus0 ();

  assign bus1.in_valid = in_valid;
  assign bus1.quad_in  = quad;
  assign bus1.x_n      = x_n;
  assign bus1.y_n      = y_n;
  assign bus1.z_n      = z_n;
  assign bus0.in_valid = in_valid;
  assign bus0.quad_in  = quad;
  assign bus0.x_n      = x_n;
  assign bus0.y_n      = y_n;
  assign bus0.z_n      = z_n;

  cordic_post #(.VALUE_WIDTH(8), .ADDRESS_WIDTH(8), .STAGES(8), .MODE(1'b1),
                .QUARTER_TURN(128)) dut_rot (.CLK(CLK), .RESET_n(RESET_n), .bus(bus1));
  cordic_post #(.VALUE_WIDTH(8), .ADDRESS_WIDTH(8), .STAGES(8), .MODE(1'b0),
                .QUARTER_TURN(128)) dut_vec (.CLK(CLK), .RESET_n(RESET_n), .bus(bus0));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", scn, tag, got, exp);
    end
  endtask

  function automatic int fdiv(input int v, input int d);
    int r;
    r = v % d;
    if (r < 0) return (v - r) / d - 1;
    return (v - r) / d;
  endfunction

  function automatic int w9(input int v);
    int r;
    r = ((v % 512) + 512) % 512;
    if (r >= 256) r -= 512;
    return r;
  endfunction

  function automatic int gm(input int v);
    return w9(fdiv(v, 2) + fdiv(v, 8) - fdiv(v, 64) - fdiv(v, 512));
  endfunction

  task automatic fill_model(input int n);
    int gx, gy;
    for (int i = 0; i < n; i++) begin
      gx = gm(sx[i]);
      gy = gm(sy[i]);
      ez[i] = sz[i];
      case (sq[i])
        1: begin ex[i] = w9(-gy); ey[i] = gx; ez0[i] = w9(sz[i] + 128); end
        2: begin ex[i] = gy; ey[i] = w9(-gx); ez0[i] = w9(sz[i] - 128); end
        default: begin ex[i] = gx; ey[i] = gy; ez0[i] = sz[i]; end
      endcase
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_x"}, bus1.x_out, 0);
    chk({tag, "_y"}, bus1.y_out, 0);
    chk({tag, "_z"}, bus1.z_out, 0);
    chk({tag, "_v"}, bus1.out_valid, 0);
    chk({tag, "_err"}, bus1.err_quad, 0);
    chk({tag, "_cnt"}, bus1.sample_cnt, 0);
    chk({tag, "_z0"}, bus0.z_out, 0);
  endtask

  task automatic clear_model();
    exp_cnt = 0; exp_err = 0;
    last_x = 0; last_y = 0; last_z = 0; last_z0 = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    RESET_n = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(posedge CLK);
    #1;
    RESET_n = 1'b1;
    clear_model();
  endtask

  // Entry cycle c: in_valid/tag; cycle c+8: data; cycle c+10: result visible
  task automatic run(input int n);
    int k, j;
    for (int c = 0; c < n + 12; c++) begin
      k = c - 10;
      j = c - 8;
      if (k >= 0 && k < n) begin
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        if (sq[k] == 3) exp_err = 1;
        last_x = ex[k]; last_y = ey[k]; last_z = ez[k]; last_z0 = ez0[k];
        chk("valid", bus1.out_valid, 1);
        chk("valid0", bus0.out_valid, 1);
      end else begin
        chk("novalid", bus1.out_valid, 0);
        chk("novalid0", bus0.out_valid, 0);
      end
      chk("x", bus1.x_out, last_x);
      chk("y", bus1.y_out, last_y);
      chk("z", bus1.z_out, last_z);
      chk("z0", bus0.z_out, last_z0);
      chk("cnt", bus1.sample_cnt, exp_cnt);
      chk("err", bus1.err_quad, exp_err);
      in_valid = (c < n);
      quad = (c < n) ? 2'(sq[c]) : 2'd0;
      if (j >= 0 && j < n) begin
        x_n = 9'(sx[j]); y_n = 9'(sy[j]); z_n = 9'(sz[j]);
      end else begin
        x_n = 9'($urandom); y_n = 9'($urandom); z_n = 9'($urandom);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    scn = "reset";
    do_reset();

    scn = "s1";
    sq[0] = 0; sx[0] = 200; sy[0] = -200; sz[0] = 77;
    ex[0] = 122; ey[0] = -120; ez[0] = 77; ez0[0] = 77;
    run(1);
    chk("s1_cnt", bus1.sample_cnt, 1);

    scn = "s2";
    sq[0] = 1; sx[0] = 200; sy[0] = -200; sz[0] = 10;
    ex[0] = 120; ey[0] = 122; ez[0] = 10; ez0[0] = 138;
    sq[1] = 2; sx[1] = 200; sy[1] = -200; sz[1] = 10;
    ex[1] = -120; ey[1] = -122; ez[1] = 10; ez0[1] = -118;
    run(2);

    scn = "s3";
    sq[0] = 1; sx[0] = 64; sy[0] = -64; sz[0] = 200;
    ex[0] = 38; ey[0] = 39; ez[0] = 200; ez0[0] = -184;
    sq[1] = 2; sx[1] = 64; sy[1] = -64; sz[1] = -200;
    ex[1] = -38; ey[1] = -39; ez[1] = -200; ez0[1] = 184;
    run(2);

    scn = "s4";
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sq[i] = i % 3;
      sx[i] = w9(i * 37 - 180);
      sy[i] = w9(200 - i * 53);
      sz[i] = w9(i * 29 - 250);
    end
    fill_model(20);
    run(20);
    chk("s4_cnt", bus1.sample_cnt, 20);

    scn = "s5";
    sq[0] = 3; sx[0] = 200; sy[0] = -200; sz[0] = -3;
    ex[0] = 122; ey[0] = -120; ez[0] = -3; ez0[0] = -3;
    run(1);
    repeat (3) @(posedge CLK);
    #1;
    chk("s5_sticky", bus1.err_quad, 1);

    scn = "s6";
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3);
      quad = 2'd1;
      @(posedge CLK);
      #1;
    end
    #2;
    RESET_n = 1'b0;
    #1;
    check_all_zero("s6_rst");
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET_n = 1'b1;
    clear_model();
    seen = 0;
    for (int c = 0; c < 16; c++) begin
      x_n = 9'($urandom); y_n = 9'($urandom); z_n = 9'($urandom);
      @(posedge CLK);
      #1;
      if (bus1.out_valid || bus0.out_valid) seen = 1;
    end
    chk("s6_no_ghost", seen, 0);
    chk("s6_cnt_zero", bus1.sample_cnt, 0);
    sq[0] = 0; sx[0] = -100; sy[0] = 17; sz[0] = 5;
    ex[0] = -60; ey[0] = 10; ez[0] = 5; ez0[0] = 5;
    run(1);
    chk("s6_cnt", bus1.sample_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
